vedic_mac_accum: RTL

VEDIC_MAC_ACCUM -- requirements
Module: vedic_mac_accum

---
 rtl/vedic_mac_accum.sv | 102 ++++++++++
 1 files changed

// File: rtl/vedic_mac_accum.sv
// Accumulates a run of unsigned 8-bit products from an upstream 4x4 multiplier
// into a saturating ACC_W-bit sum. The result is then held until the consumer
// takes it.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; the last result stays visible on acc_o/sat_o
// ACCUM | accepting products (in_ready=1) until len products are summed
// DONE  | result valid (out_valid=1), held until out_ready
module vedic_mac_accum #(
   parameter int ACC_W = 12,
   parameter int LEN_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   input  logic [7:0]       product,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_o,
   output logic             sat_o,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [ACC_W-1:0] acc;
   logic             sat;
   logic [LEN_W-1:0] count;
   logic [LEN_W-1:0] len_q;
   logic [ACC_W:0]   sum;
   logic             accept;
   logic             take;
   logic             last;

   // Carry bit of sum flags overflow; the clamp and the sticky flag both key off it.
   assign sum    = {1'b0, acc} + (ACC_W+1)'(product);
   assign accept = (state == IDLE) && start;
   assign take   = (state == ACCUM) && in_valid;
   assign last   = (count + LEN_W'(1)) == len_q;

   assign acc_o  = acc;
   assign sat_o  = sat;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state and status decode, all taken from the state register.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = (len == '0) ? DONE : ACCUM;
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid && last) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: clear on an accepted start, saturating add on each transfer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc   <= '0;
         sat   <= 1'b0;
         count <= '0;
         len_q <= '0;
      end else if (accept) begin
         acc   <= '0;
         sat   <= 1'b0;
         count <= '0;
         len_q <= len;
      end else if (take) begin
         acc   <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
         sat   <= sat | sum[ACC_W];
         count <= count + LEN_W'(1);
      end
   end

endmodule
